// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the fetch PC, keeps at most one imem request
// in flight, and buffers returned {PC,IR} pairs for the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        EN,
    output logic        Out,
    output logic [31:0] IR,
    output logic [31:0] PC
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_KILL
    } state_t;

    state_t state, state_next;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [31:0]   buf_pc [FIFO_DEPTH];
    logic [31:0]   buf_ir [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   count_after;
    logic          pop;
    logic          push;
    logic          has_space;
    logic          accept;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign Out       = (count != '0);
    assign IR        = Out ? buf_ir[rd_ptr] : '0;
    assign PC        = Out ? buf_pc[rd_ptr] : '0;
    assign imem_addr = fetch_pc;

    // Space accounts for this cycle's push/pop so an accepted request always
    // has a free slot when its data returns.
    always_comb begin
        pop         = Out && EN && !redirect;
        push        = (state == S_WAIT) && imem_rvalid && !redirect;
        count_after = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
        has_space   = count_after < (CW+1)'(FIFO_DEPTH);
        imem_req    = !RST && !redirect && has_space &&
                      ((state == S_IDLE) || ((state == S_WAIT) && imem_rvalid));
        accept      = imem_req && imem_ready;

        state_next = state;
        if (redirect) begin
            if (state != S_IDLE) begin
                state_next = imem_rvalid ? S_IDLE : S_KILL;
            end
        end else begin
            case (state)
                S_IDLE: if (accept) state_next = S_WAIT;
                S_WAIT: if (imem_rvalid) state_next = accept ? S_WAIT : S_IDLE;
                S_KILL: if (imem_rvalid) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (redirect) begin
                fetch_pc <= redirect_pc & ~32'd3;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (accept) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                count <= count_after[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[wr_ptr] <= req_pc;
            buf_ir[wr_ptr] <= imem_rdata;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (RST)
        !(push && !pop && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector tables, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_if_fetch_unit;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_ready, imem_rvalid, redirect, en;
    logic [31:0] imem_rdata, redirect_pc;
    logic        req, out;
    logic [31:0] addr, ir, pc;
    logic        req_w, out_w;
    logic [31:0] addr_w, ir_w, pc_w;

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .RST(rst),
        .imem_req(req), .imem_addr(addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .EN(en),
        .Out(out), .IR(ir), .PC(pc)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .RST(rst),
        .imem_req(req_w), .imem_addr(addr_w), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .EN(en),
        .Out(out_w), .IR(ir_w), .PC(pc_w)
    );

    typedef struct {
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        en;
        logic        redirect;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        out;
        logic [31:0] pc;
        logic [31:0] ir;
    } vec_t;

    vec_t t1[6];
    vec_t t2[8];

    function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rd, logic e,
                                logic rdr, logic [31:0] rp, logic q,
                                logic [31:0] a, logic o, logic [31:0] p,
                                logic [31:0] i);
        vec_t v;
        v.ready = rdy; v.rvalid = rv; v.rdata = rd; v.en = e;
        v.redirect = rdr; v.rpc = rp;
        v.req = q; v.addr = a; v.out = o; v.pc = p; v.ir = i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input vec_t v, input string tag);
        imem_ready  = v.ready;
        imem_rvalid = v.rvalid;
        imem_rdata  = v.rdata;
        en          = v.en;
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        @(negedge clk);
        chk({tag, ".req"},  {31'b0, req}, {31'b0, v.req});
        chk({tag, ".addr"}, addr, v.addr);
        chk({tag, ".out"},  {31'b0, out}, {31'b0, v.out});
        chk({tag, ".pc"},   pc, v.pc);
        chk({tag, ".ir"},   ir, v.ir);
        next_cycle();
    endtask

    task automatic do_reset();
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        en = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rst = 1'b1;
        #1;
        chk("rst.out",   {31'b0, out}, 32'd0);
        chk("rst.ir",    ir, 32'd0);
        chk("rst.pc",    pc, 32'd0);
        chk("rst.req",   {31'b0, req}, 32'd0);
        chk("rst.addr",  addr, 32'd0);
        chk("rst.waddr", addr_w, 32'hFFFF_FFFC);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // reference model state
    logic [31:0] q_pc[$];
    logic [31:0] q_ir[$];
    logic [31:0] m_fetch, m_req_pc;
    bit          m_busy, m_drop;
    bit          mem_pend;
    logic [31:0] mem_a;
    int unsigned mem_dly;
    int          space;
    bit          e_req, e_pop, e_push;

    initial begin
        t1[0] = mk(1, 0, 32'h0,         1, 0, 0, 1, 32'h00, 0, 32'h0, 32'h0);
        t1[1] = mk(1, 1, 32'hA5A5_0000, 1, 0, 0, 1, 32'h04, 0, 32'h0, 32'h0);
        t1[2] = mk(1, 1, 32'hA5A5_0004, 1, 0, 0, 1, 32'h08, 1, 32'h0, 32'hA5A5_0000);
        t1[3] = mk(1, 1, 32'hA5A5_0008, 1, 0, 0, 1, 32'h0C, 1, 32'h4, 32'hA5A5_0004);
        t1[4] = mk(1, 1, 32'hA5A5_000C, 1, 0, 0, 1, 32'h10, 1, 32'h8, 32'hA5A5_0008);
        t1[5] = mk(1, 1, 32'hA5A5_0010, 1, 0, 0, 1, 32'h14, 1, 32'hC, 32'hA5A5_000C);

        t2[0] = mk(1, 0, 32'h0,         0, 0, 0, 1, 32'h00, 0, 32'h0, 32'h0);
        t2[1] = mk(1, 1, 32'hA5A5_0000, 0, 0, 0, 1, 32'h04, 0, 32'h0, 32'h0);
        t2[2] = mk(1, 1, 32'hA5A5_0004, 0, 0, 0, 0, 32'h08, 1, 32'h0, 32'hA5A5_0000);
        t2[3] = mk(1, 0, 32'h0,         0, 0, 0, 0, 32'h08, 1, 32'h0, 32'hA5A5_0000);
        t2[4] = mk(1, 0, 32'h0,         0, 0, 0, 0, 32'h08, 1, 32'h0, 32'hA5A5_0000);
        t2[5] = mk(1, 0, 32'h0,         1, 0, 0, 1, 32'h08, 1, 32'h0, 32'hA5A5_0000);
        t2[6] = mk(1, 1, 32'hA5A5_0008, 1, 0, 0, 1, 32'h0C, 1, 32'h4, 32'hA5A5_0004);
        t2[7] = mk(1, 1, 32'hA5A5_000C, 1, 0, 0, 1, 32'h10, 1, 32'h8, 32'hA5A5_0008);

        // streaming with single-cycle memory
        do_reset();
        for (int i = 0; i < 6; i++) step(t1[i], $sformatf("stream%0d", i));

        // back-pressure fills the buffer
        do_reset();
        for (int i = 0; i < 8; i++) step(t2[i], $sformatf("bp%0d", i));

        // redirect while a delayed fetch is outstanding
        do_reset();
        step(mk(1, 0, 32'h0,         1, 0, 0,        1, 32'h000, 0, 32'h0,   32'h0), "kill0");
        step(mk(1, 1, 32'hA5A5_0000, 1, 0, 0,        1, 32'h004, 0, 32'h0,   32'h0), "kill1");
        step(mk(1, 1, 32'hA5A5_0004, 1, 0, 0,        1, 32'h008, 1, 32'h0,   32'hA5A5_0000), "kill2");
        step(mk(1, 0, 32'h0,         0, 1, 32'h103,  0, 32'h00C, 1, 32'h4,   32'hA5A5_0004), "kill3");
        step(mk(1, 0, 32'h0,         0, 0, 0,        0, 32'h100, 0, 32'h0,   32'h0), "kill4");
        step(mk(1, 0, 32'h0,         0, 0, 0,        0, 32'h100, 0, 32'h0,   32'h0), "kill5");
        step(mk(1, 1, 32'hA5A5_0008, 0, 0, 0,        0, 32'h100, 0, 32'h0,   32'h0), "kill6");
        step(mk(1, 0, 32'h0,         1, 0, 0,        1, 32'h100, 0, 32'h0,   32'h0), "kill7");
        step(mk(1, 1, 32'hA5A5_0100, 1, 0, 0,        1, 32'h104, 0, 32'h0,   32'h0), "kill8");
        step(mk(1, 1, 32'hA5A5_0104, 1, 0, 0,        1, 32'h108, 1, 32'h100, 32'hA5A5_0100), "kill9");

        // redirect, rvalid and EN in the same cycle
        do_reset();
        step(mk(1, 0, 32'h0,         1, 0, 0,       1, 32'h000, 0, 32'h0,   32'h0), "rsim0");
        step(mk(1, 1, 32'hA5A5_0000, 1, 0, 0,       1, 32'h004, 0, 32'h0,   32'h0), "rsim1");
        step(mk(1, 1, 32'hA5A5_0004, 1, 1, 32'h200, 0, 32'h008, 1, 32'h0,   32'hA5A5_0000), "rsim2");
        step(mk(0, 0, 32'h0,         1, 0, 0,       1, 32'h200, 0, 32'h0,   32'h0), "rsim3");
        step(mk(1, 0, 32'h0,         1, 0, 0,       1, 32'h200, 0, 32'h0,   32'h0), "rsim4");
        step(mk(1, 1, 32'hA5A5_0200, 1, 0, 0,       1, 32'h204, 0, 32'h0,   32'h0), "rsim5");
        step(mk(1, 1, 32'hA5A5_0204, 1, 0, 0,       1, 32'h208, 1, 32'h200, 32'hA5A5_0200), "rsim6");

        // fetch PC wraps from the top of the address space
        do_reset();
        imem_ready = 1; imem_rvalid = 0; imem_rdata = '0; en = 1;
        @(negedge clk);
        chk("wrap.req0",  {31'b0, req_w}, 32'd1);
        chk("wrap.addr0", addr_w, 32'hFFFF_FFFC);
        next_cycle();
        imem_rvalid = 1; imem_rdata = 32'hFFFF_FFFC ^ 32'hA5A5_0000;
        @(negedge clk);
        chk("wrap.req1",  {31'b0, req_w}, 32'd1);
        chk("wrap.addr1", addr_w, 32'h0000_0000);
        next_cycle();
        imem_rdata = 32'hA5A5_0000;
        @(negedge clk);
        chk("wrap.out", {31'b0, out_w}, 32'd1);
        chk("wrap.pc",  pc_w, 32'hFFFF_FFFC);
        chk("wrap.ir",  ir_w, 32'h5A5A_FFFC);
        next_cycle();

        // asynchronous reset in the middle of an outstanding fetch
        do_reset();
        step(mk(1, 0, 32'h0,         1, 0, 0, 1, 32'h000, 0, 32'h0, 32'h0), "areset0");
        step(mk(1, 1, 32'hA5A5_0000, 0, 0, 0, 1, 32'h004, 0, 32'h0, 32'h0), "areset1");
        imem_ready = 0; imem_rvalid = 0; en = 0;
        #1;
        chk("areset.pre_out", {31'b0, out}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("areset.out", {31'b0, out}, 32'd0);
        chk("areset.ir",  ir, 32'd0);
        chk("areset.pc",  pc, 32'd0);
        chk("areset.req", {31'b0, req}, 32'd0);
        rst = 1'b0;
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("areset.addr", addr, 32'd0);
        chk("areset.req1", {31'b0, req}, 32'd1);
        next_cycle();
        imem_rvalid = 0;
        @(negedge clk);
        chk("areset.stale_out", {31'b0, out}, 32'd0);
        chk("areset.req2",      {31'b0, req}, 32'd1);
        next_cycle();

        // randomized traffic against the reference model
        do_reset();
        q_pc.delete(); q_ir.delete();
        m_fetch = 32'h0; m_req_pc = 32'h0; m_busy = 0; m_drop = 0;
        mem_pend = 0; mem_a = '0; mem_dly = 0;
        for (int n = 0; n < 3000; n++) begin
            imem_ready  = ($urandom_range(0, 99) < 70);
            en          = ($urandom_range(0, 99) < 60);
            redirect    = ($urandom_range(0, 99) < 6);
            redirect_pc = $urandom;
            if (mem_pend) begin
                imem_rvalid = (mem_dly == 0);
                imem_rdata  = mem_a ^ 32'hA5A5_0000;
            end else begin
                imem_rvalid = ($urandom_range(0, 99) < 10);
                imem_rdata  = $urandom;
            end
            e_pop  = (q_pc.size() > 0) && en && !redirect;
            e_push = m_busy && !m_drop && imem_rvalid && !redirect;
            space  = DEPTH - q_pc.size() + int'(e_pop) - int'(e_push);
            e_req  = !redirect && (space > 0) &&
                     (!m_busy || (!m_drop && imem_rvalid));

            @(negedge clk);
            chk("rand.req",  {31'b0, req}, {31'b0, e_req});
            chk("rand.addr", addr, m_fetch);
            chk("rand.out",  {31'b0, out}, {31'b0, (q_pc.size() > 0)});
            chk("rand.pc",   pc, (q_pc.size() > 0) ? q_pc[0] : 32'h0);
            chk("rand.ir",   ir, (q_ir.size() > 0) ? q_ir[0] : 32'h0);
            @(posedge clk);

            if (redirect) begin
                q_pc.delete(); q_ir.delete();
                m_fetch = redirect_pc & ~32'd3;
                if (m_busy && imem_rvalid) begin
                    m_busy = 0; m_drop = 0;
                end else if (m_busy) begin
                    m_drop = 1;
                end
            end else begin
                if (e_pop) begin
                    void'(q_pc.pop_front());
                    void'(q_ir.pop_front());
                end
                if (m_busy && imem_rvalid) begin
                    if (!m_drop) begin
                        q_pc.push_back(m_req_pc);
                        q_ir.push_back(imem_rdata);
                    end
                    m_busy = 0; m_drop = 0;
                end
                if (e_req && imem_ready) begin
                    m_busy = 1; m_drop = 0;
                    m_req_pc = m_fetch;
                    m_fetch = m_fetch + 32'd4;
                end
            end

            if (mem_pend && imem_rvalid) mem_pend = 0;
            else if (mem_pend && mem_dly > 0) mem_dly--;
            if (e_req && imem_ready) begin
                mem_pend = 1;
                mem_a    = m_req_pc;
                mem_dly  = $urandom_range(0, 3);
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
